// File: rtl/wptr_ctrl_if.sv
// Write-side pointer controller bus: request/threshold inputs and pointer/flag outputs.
// Build macro WPTR_OVF_CNT_EN adds the ovf_count signal.
interface wptr_ctrl_if #(
    parameter int unsigned PTR_WIDTH     = 3,
    parameter int unsigned OVF_CNT_WIDTH = 8
);
    logic                   w_en;
    logic [PTR_WIDTH:0]     g_rptr_sync;
    logic [PTR_WIDTH:0]     af_thresh;
    logic                   ovf_clr;
    logic                   w_push;
    logic [PTR_WIDTH-1:0]   waddr;
    logic [PTR_WIDTH:0]     b_wptr;
    logic [PTR_WIDTH:0]     g_wptr;
    logic                   wr_ack;
    logic                   full;
    logic                   almost_full;
    logic [PTR_WIDTH:0]     wlevel;
    logic                   overflow;
`ifdef WPTR_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_count;

    modport master (
        output w_en, g_rptr_sync, af_thresh, ovf_clr,
        input  w_push, waddr, b_wptr, g_wptr, wr_ack, full, almost_full, wlevel, overflow, ovf_count
    );
    modport slave (
        input  w_en, g_rptr_sync, af_thresh, ovf_clr,
        output w_push, waddr, b_wptr, g_wptr, wr_ack, full, almost_full, wlevel, overflow, ovf_count
    );
`else
    modport master (
        output w_en, g_rptr_sync, af_thresh, ovf_clr,
        input  w_push, waddr, b_wptr, g_wptr, wr_ack, full, almost_full, wlevel, overflow
    );
    modport slave (
        input  w_en, g_rptr_sync, af_thresh, ovf_clr,
        output w_push, waddr, b_wptr, g_wptr, wr_ack, full, almost_full, wlevel, overflow
    );
`endif
endinterface

// File: rtl/wptr_ctrl.sv
// Async FIFO write-side pointer controller: binary/Gray pointers, full, almost-full, level, ack, overflow.
// Build macro WPTR_OVF_CNT_EN adds a saturating rejected-write counter (ovf_count).
module wptr_ctrl #(
    parameter int unsigned PTR_WIDTH     = 3,
    parameter int unsigned OVF_CNT_WIDTH = 8
) (
    input  logic       wclk,
    input  logic       wrst,
    wptr_ctrl_if.slave wif
);
    logic [PTR_WIDTH:0] b_wptr_q, g_wptr_q, wlevel_q;
    logic [PTR_WIDTH:0] b_next, g_next, b_rsync, lvl_next, g_rfull;
    logic               full_q, almost_full_q, wr_ack_q, overflow_q;
    logic               w_push, rejected, full_next;

    assign w_push   = wif.w_en & ~full_q;
    assign rejected = wif.w_en & full_q;
    assign b_next   = b_wptr_q + (PTR_WIDTH+1)'(w_push);
    assign g_next   = b_next ^ (b_next >> 1);

    // Bit i of the XOR of all right shifts is the XOR of g[PTR_WIDTH:i].
    always_comb begin
        b_rsync = '0;
        for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
            b_rsync = b_rsync ^ (wif.g_rptr_sync >> i);
        end
    end

    assign lvl_next  = b_next - b_rsync;
    assign g_rfull   = {~wif.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], wif.g_rptr_sync[PTR_WIDTH-2:0]};
    assign full_next = (g_next == g_rfull);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            b_wptr_q      <= '0;
            g_wptr_q      <= '0;
            wlevel_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            b_wptr_q      <= b_next;
            g_wptr_q      <= g_next;
            wlevel_q      <= lvl_next;
            full_q        <= full_next;
            almost_full_q <= (lvl_next >= wif.af_thresh);
            wr_ack_q      <= w_push;
            if (rejected)
                overflow_q <= 1'b1;
            else if (wif.ovf_clr)
                overflow_q <= 1'b0;
        end
    end

    assign wif.w_push      = w_push;
    assign wif.waddr       = b_wptr_q[PTR_WIDTH-1:0];
    assign wif.b_wptr      = b_wptr_q;
    assign wif.g_wptr      = g_wptr_q;
    assign wif.wlevel      = wlevel_q;
    assign wif.full        = full_q;
    assign wif.almost_full = almost_full_q;
    assign wif.wr_ack      = wr_ack_q;
    assign wif.overflow    = overflow_q;

`ifdef WPTR_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_count_q;

    // A clear coinciding with a rejected write restarts the count at one.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst)
            ovf_count_q <= '0;
        else if (wif.ovf_clr)
            ovf_count_q <= rejected ? OVF_CNT_WIDTH'(1) : '0;
        else if (rejected && (ovf_count_q != '1))
            ovf_count_q <= ovf_count_q + OVF_CNT_WIDTH'(1);
    end

    assign wif.ovf_count = ovf_count_q;
`endif
endmodule

// File: tb/tb_wptr_ctrl.sv
// Randomised scoreboard bench for wptr_ctrl; a count-based FIFO occupancy model predicts every output.
// Build with WPTR_OVF_CNT_EN to also check ovf_count (OVF_CNT_WIDTH=2).
module tb_wptr_ctrl;
    localparam int unsigned PW    = 3;
    localparam int unsigned DEPTH = 8;
`ifdef WPTR_OVF_CNT_EN
    localparam int unsigned OCW = 2;
`else
    localparam int unsigned OCW = 8;
`endif
    localparam int unsigned CNT_MAX = (1 << OCW) - 1;

    typedef struct {
        logic        push;
        logic [3:0]  b;
        logic [3:0]  g;
        logic [3:0]  lvl;
        logic        ack;
        logic        full;
        logic        af;
        logic        ovf;
        int unsigned cnt;
    } exp_t;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    exp_t q[$];

    // Model: total words written/read since reset; everything else derives from these.
    int unsigned wr_cnt = 0, rd_cnt = 0, thresh = 6, m_cnt = 0;
    bit m_full = 1'b0, m_ovf = 1'b0;

    wptr_ctrl_if #(.PTR_WIDTH(PW), .OVF_CNT_WIDTH(OCW)) wif ();

    wptr_ctrl #(.PTR_WIDTH(PW), .OVF_CNT_WIDTH(OCW)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .wif  (wif)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input int unsigned v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_b_wptr"}, 32'(wif.b_wptr), 0);
        chk({tag, "_g_wptr"}, 32'(wif.g_wptr), 0);
        chk({tag, "_wr_ack"}, 32'(wif.wr_ack), 0);
        chk({tag, "_full"}, 32'(wif.full), 0);
        chk({tag, "_almost_full"}, 32'(wif.almost_full), 0);
        chk({tag, "_wlevel"}, 32'(wif.wlevel), 0);
        chk({tag, "_overflow"}, 32'(wif.overflow), 0);
`ifdef WPTR_OVF_CNT_EN
        chk({tag, "_ovf_count"}, 32'(wif.ovf_count), 0);
`endif
    endtask

    // Entered at a falling edge; drives one cycle, predicts the next rising edge, returns at the next falling edge.
    task automatic cycle(input bit wen, input bit rd, input bit clr);
        exp_t e;
        int unsigned lvl;
        bit rej;
        if (rd && rd_cnt < wr_cnt) rd_cnt++;
        wif.w_en        = wen;
        wif.ovf_clr     = clr;
        wif.g_rptr_sync = gray4(rd_cnt);
        wif.af_thresh   = 4'(thresh);
        e.push = wen && !m_full;
        rej    = wen && m_full;
        if (e.push) wr_cnt++;
        lvl    = wr_cnt - rd_cnt;
        e.b    = 4'(wr_cnt);
        e.g    = gray4(wr_cnt);
        e.lvl  = 4'(lvl);
        e.ack  = e.push;
        e.full = (lvl == DEPTH);
        e.af   = (lvl >= thresh);
        if (rej) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        e.ovf  = m_ovf;
        if (clr) m_cnt = rej ? 1 : 0;
        else if (rej && m_cnt < CNT_MAX) m_cnt++;
        e.cnt  = m_cnt;
        m_full = e.full;
        q.push_back(e);
        @(negedge wclk);
    endtask

    task automatic model_reset();
        wr_cnt = 0; rd_cnt = 0; m_cnt = 0;
        m_full = 1'b0; m_ovf = 1'b0;
    endtask

    // Reset lands between edges while w_en may still be high, then is held across an edge.
    task automatic mid_reset();
        @(posedge wclk);
        #3 wrst = 1'b1;
        #1 check_zero("async_rst");
        @(posedge wclk);
        #1 check_zero("held_rst");
        @(negedge wclk);
        model_reset();
        wif.w_en        = 1'b0;
        wif.ovf_clr     = 1'b0;
        wif.g_rptr_sync = '0;
        wrst            = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wclk);
            #2;
            if (q.size() > 0) chk("w_push", 32'(wif.w_push), 32'(q[0].push));
            @(posedge wclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("b_wptr", 32'(wif.b_wptr), 32'(e.b));
                chk("waddr", 32'(wif.waddr), 32'(e.b[2:0]));
                chk("g_wptr", 32'(wif.g_wptr), 32'(e.g));
                chk("wlevel", 32'(wif.wlevel), 32'(e.lvl));
                chk("wr_ack", 32'(wif.wr_ack), 32'(e.ack));
                chk("full", 32'(wif.full), 32'(e.full));
                chk("almost_full", 32'(wif.almost_full), 32'(e.af));
                chk("overflow", 32'(wif.overflow), 32'(e.ovf));
`ifdef WPTR_OVF_CNT_EN
                chk("ovf_count", 32'(wif.ovf_count), e.cnt);
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        wif.w_en        = 1'b0;
        wif.ovf_clr     = 1'b0;
        wif.g_rptr_sync = '0;
        wif.af_thresh   = 4'(thresh);
        #1 check_zero("por");
        @(negedge wclk);
        wrst = 1'b0;

        // Burst to b_wptr=5, then reset with w_en still high.
        repeat (5) cycle(1, 0, 0);
        wif.w_en = 1'b1;
        mid_reset();

        // Fill from empty: eight accepted, ninth rejected; almost_full rises at level 6.
        repeat (9) cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 1, 0);
        cycle(0, 0, 1);
        cycle(1, 0, 0);

        // Saturating overflow count, clears alone and with a coincident reject.
        cycle(0, 0, 1);
        repeat (5) cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);

        // Threshold zero after reset, then a tracked read side through several pointer wraps.
        thresh = 0;
        mid_reset();
        repeat (40) cycle(1, (wr_cnt - rd_cnt >= 5) ? 1'b1 : 1'($urandom_range(0, 1)), 0);

        thresh = 6;
        for (int i = 0; i < 400; i++) begin
            if (i % 64 == 0) thresh = $urandom_range(0, 8);
            if (i == 200) mid_reset();
            if (i < 200)
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            else
                cycle($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        repeat (4) @(posedge wclk);
        #2 chk("scoreboard_drain", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wptr_ctrl.md
Name: wptr_ctrl

Overview:
Write-side pointer controller for the async FIFO, replacing the basic write pointer handler. It keeps the binary and Gray write pointers and registers the full flag. It adds a write-domain fill level, a programmable almost-full flag, a registered write acknowledge, and a sticky overflow flag. It sits in the write clock domain and takes the read pointer as a Gray code that is already synchronised into wclk.

Parameters:
PTR_WIDTH, 3, address width; FIFO depth = 2**PTR_WIDTH; must be >= 2
OVF_CNT_WIDTH, 8, width of the optional overflow counter

Ports:
wclk  input  1  write clock
wrst  input  1  asynchronous reset, active-high
w_en  input  1  write request
g_rptr_sync  input  PTR_WIDTH+1  Gray read pointer, synchronised into wclk
af_thresh  input  PTR_WIDTH+1  almost-full threshold, in entries (quasi-static)
ovf_clr  input  1  clears the sticky overflow flag
w_push  output  1  combinational; write accepted this cycle (RAM write enable)
waddr  output  PTR_WIDTH  RAM write address = b_wptr[PTR_WIDTH-1:0]
b_wptr  output  PTR_WIDTH+1  binary write pointer
g_wptr  output  PTR_WIDTH+1  Gray write pointer (sent to the read-domain synchroniser)
wr_ack  output  1  registered; a write was accepted on the previous edge
full  output  1  registered full flag
almost_full  output  1  registered almost-full flag
wlevel  output  PTR_WIDTH+1  registered fill level, 0..2**PTR_WIDTH
overflow  output  1  sticky; a write was attempted while full

Behaviour:
- Reset: while wrst=1, all registered outputs are 0 (b_wptr, g_wptr, wr_ack, full, almost_full, wlevel, overflow, and ovf_count if present). Reset acts immediately, also mid-burst.
- w_push = w_en & ~full.
- b_next = b_wptr + w_push, computed modulo 2**(PTR_WIDTH+1).
- g_next = b_next ^ (b_next >> 1).
- b_wptr <= b_next and g_wptr <= g_next each edge.
- Gray-to-binary of the read pointer, combinational: b_rsync[i] = XOR of g_rptr_sync[PTR_WIDTH:i].
- lvl_next = b_next - b_rsync, modulo 2**(PTR_WIDTH+1).
- wlevel <= lvl_next.
- full <= (g_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}). This is equivalent to lvl_next == 2**PTR_WIDTH.
- full asserts on the same edge that registers the last accepted write.
- almost_full <= (lvl_next >= af_thresh). With af_thresh=0, almost_full is 1 from the first edge after reset release.
- wr_ack <= w_push, so an accepted write is acknowledged with 1-cycle latency.
- overflow: set on any edge where w_en & full; cleared by ovf_clr; set has priority over clear.
- Write while full: the write is dropped; pointers, wlevel and wr_ack (0) hold.
- Flag release: flags are conservative, because synchroniser lag only makes them over-report.
  - full is registered from the previous edge. If the read pointer advances, full releases one edge after the new g_rptr_sync is seen.
  - A write presented in that cycle is rejected and sets overflow.
- Wrap-around:
  - b_wptr wraps 2**(PTR_WIDTH+1)-1 -> 0.
  - g_wptr wraps {1,0...0} -> 0.
  - wlevel stays correct across the wrap.
- The block has no internal FSM beyond these registers. The RAM and the synchronisers are outside it.

Optional Feature:
Macro WPTR_OVF_CNT_EN.
- Defined: adds output ovf_count [OVF_CNT_WIDTH-1:0], a saturating count of rejected writes (w_en & full).
  - ovf_clr alone sets it to 0.
  - ovf_clr together with a rejected write sets it to 1.
  - It saturates at all-ones.
  - Reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use PTR_WIDTH=3.
- Reset mid-burst: with b_wptr=5, assert wrst asynchronously between edges -> all outputs are 0 before the next edge; nothing changes during reset.
- Fill: g_rptr_sync=0, w_en=1 for 9 cycles.
  - Edges 1-8: w_push=1 and wr_ack follows one cycle later.
  - Edge 8: b_wptr=4'b1000, g_wptr=4'b1100, wlevel=8, full=1.
  - 9th cycle: w_push=0, b_wptr holds at 8, overflow=1.
- Almost full: af_thresh=6, single writes from empty -> almost_full=0 at wlevel=5; it rises on the edge that registers wlevel=6.
- Wrap: drive g_rptr_sync to track the read side, keeping level < 8, and stream 20 writes -> b_wptr passes 15->0 and g_wptr passes 4'b1000->4'b0000; wlevel is correct at each edge; full never asserts.
- Overflow clear:
  - ovf_clr=1 with full=0 -> overflow=0 on the next edge.
  - ovf_clr=1 together with w_en=1 while full=1 -> overflow stays 1.
- Counter (WPTR_OVF_CNT_EN, OVF_CNT_WIDTH=2): 5 rejected writes -> ovf_count=3 (saturated); then ovf_clr alone -> ovf_count=0.
